// File: rtl/throw_sequencer.sv
// throw_sequencer: frame-rate hammer-throw sequencer (aim, spin, release, flight, land).
// Optional THROW_FOUL_EN: reject throws with fewer than MIN_QUARTERS quarter-turns.
module throw_sequencer #(
  parameter int CX           = 335,
  parameter int CY           = 200,
`ifdef THROW_FOUL_EN
  parameter int MIN_QUARTERS = 4,
`endif
  parameter int FRAMES_PER_Q = 6,
  parameter int LAND_FRAMES  = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  output logic [7:0]  cmd_keycode,
  output logic [2:0]  state,
  output logic [7:0]  quarters,
  output logic [15:0] distance,
  output logic        throw_valid,
  output logic        foul,
  output logic        oob
);

  localparam logic [9:0]  LP_CX   = 10'(CX);
  localparam logic [9:0]  LP_CY   = 10'(CY);
  localparam logic [15:0] LP_FPQ  = 16'(FRAMES_PER_Q);
  localparam logic [15:0] LP_LAST = 16'(LAND_FRAMES - 1);
  localparam logic [7:0]  K_SPC   = 8'h2C;
  localparam logic [7:0]  K_A     = 8'h04;
  localparam logic [7:0]  K_D     = 8'h07;
  localparam logic [7:0]  K_S     = 8'h16;
  localparam logic [7:0]  K_W     = 8'h1A;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WIND = 3'd1,
    S_REL  = 3'd2,
    S_FLT  = 3'd3,
    S_LAND = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cmd;
  logic [7:0]  w_cmd;
  logic [7:0]  r_quarters;
  logic [7:0]  r_fkey;
  logic [7:0]  w_fkey;
  logic [15:0] r_distance;
  logic [15:0] r_budget;
  logic [15:0] r_land;
  logic [15:0] w_budget;
  logic [1:0]  r_prev_q;
  logic [1:0]  w_quad;
  logic        r_valid;
  logic        r_oob;
  logic        w_xlt;
  logic        w_ylt;
  logic        w_ccw;
  logic        w_oob_hit;
  logic        w_foul_chk;
  logic        w_key_ok;

  always_comb begin
    w_xlt = BallX < LP_CX;
    w_ylt = BallY < LP_CY;
    unique case ({w_xlt, w_ylt})
      2'b01:   w_quad = 2'd0;
      2'b11:   w_quad = 2'd1;
      2'b10:   w_quad = 2'd2;
      default: w_quad = 2'd3;
    endcase
    // tangential launch direction for each quadrant
    unique case (w_quad)
      2'd0:    w_fkey = K_A;
      2'd1:    w_fkey = K_S;
      2'd2:    w_fkey = K_D;
      default: w_fkey = K_W;
    endcase
  end

  assign w_ccw     = (w_quad == r_prev_q + 2'd1);
  assign w_budget  = 16'(r_quarters) * LP_FPQ;
  assign w_oob_hit = (r_distance >= 16'd2) &&
                     (BallX == LP_CX) &&
                     (BallY == LP_CY);
  assign w_key_ok  = (keycode == K_A) || (keycode == K_D) ||
                     (keycode == K_S) || (keycode == K_W);

`ifdef THROW_FOUL_EN
  assign w_foul_chk = r_quarters < 8'(MIN_QUARTERS);
`else
  assign w_foul_chk = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else if (frame_tick) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (frame_tick) begin
      unique case (r_state)
        S_IDLE: if (keycode == K_SPC) w_next = S_WIND;
        S_WIND: if (keycode != K_SPC) w_next = S_REL;
        S_REL: begin
          if (w_foul_chk)            w_next = S_IDLE;
          else if (w_budget == '0)   w_next = S_LAND;
          else                       w_next = S_FLT;
        end
        S_FLT: begin
          if (w_oob_hit || r_budget == 16'd1)
            w_next = S_LAND;
        end
        S_LAND: if (r_land == LP_LAST) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd = 8'h00;
    unique case (w_next)
      S_IDLE: begin
        if (r_state == S_IDLE && w_key_ok)
          w_cmd = keycode;
      end
      S_WIND: w_cmd = K_SPC;
      S_FLT:  w_cmd = (r_state == S_REL) ? w_fkey : r_fkey;
      default: w_cmd = 8'h00;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cmd      <= '0;
      r_quarters <= '0;
      r_distance <= '0;
      r_budget   <= '0;
      r_land     <= '0;
      r_prev_q   <= '0;
      r_fkey     <= '0;
      r_valid    <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (frame_tick) begin
        r_cmd    <= w_cmd;
        r_prev_q <= w_quad;
        unique case (r_state)
          S_IDLE: begin
            if (w_next == S_WIND) begin
              r_quarters <= '0;
              r_distance <= '0;
              r_oob      <= 1'b0;
            end
          end
          S_WIND: begin
            if (w_ccw && r_quarters != 8'hFF)
              r_quarters <= r_quarters + 8'd1;
          end
          S_REL: begin
            r_fkey   <= w_fkey;
            r_budget <= w_budget;
            r_land   <= '0;
            r_valid  <= (w_next == S_LAND);
          end
          S_FLT: begin
            r_distance <= r_distance + 16'd1;
            r_budget   <= r_budget - 16'd1;
            r_land     <= '0;
            r_valid    <= (w_next == S_LAND);
            if (w_oob_hit) r_oob <= 1'b1;
          end
          S_LAND: r_land <= r_land + 16'd1;
          default: r_land <= '0;
        endcase
      end
    end
  end

`ifdef THROW_FOUL_EN
  logic r_foul;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_foul <= 1'b0;
    else r_foul <= frame_tick && (r_state == S_REL) && w_foul_chk;
  end

  assign foul = r_foul;
`else
  assign foul = 1'b0;
`endif

  assign state       = r_state;
  assign cmd_keycode = r_cmd;
  assign quarters    = r_quarters;
  assign distance    = r_distance;
  assign throw_valid = r_valid;
  assign oob         = r_oob;

endmodule

// File: tb/tb_throw_sequencer.sv
// tb_throw_sequencer: random and directed hammer throws against a frame-level model.
// Define THROW_FOUL_EN for both files to exercise the foul path.
module tb_throw_sequencer;

  localparam int CX    = 335;
  localparam int CY    = 200;
  localparam int FPQ   = 6;
  localparam int LANDF = 60;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  BallX = 10'(CX + 20);
  logic [9:0]  BallY = 10'(CY - 20);
  logic [7:0]  cmd_keycode;
  logic [2:0]  state;
  logic [7:0]  quarters;
  logic [15:0] distance;
  logic        throw_valid;
  logic        foul;
  logic        oob;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  throw_sequencer dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_tick(frame_tick),
    .keycode(keycode),
    .BallX(BallX),
    .BallY(BallY),
    .cmd_keycode(cmd_keycode),
    .state(state),
    .quarters(quarters),
    .distance(distance),
    .throw_valid(throw_valid),
    .foul(foul),
    .oob(oob)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0h want %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // frame-level model: phase 0..4 = idle/wind/release/flight/land
  int m_st = 0, m_cmd = 0, m_q = 0, m_d = 0, m_oob = 0;
  int m_tv = 0, m_foul = 0, m_pq = 0, m_bud = 0;
  int m_fkey = 0, m_land = 0;
  int fkey_of [4] = '{8'h04, 8'h16, 8'h07, 8'h1A};

  function automatic int quad(int x, int y);
    if (x >= CX) return (y < CY) ? 0 : 3;
    return (y < CY) ? 1 : 2;
  endfunction

  function automatic bit walk_key(int k);
    return k == 8'h04 || k == 8'h07 ||
           k == 8'h16 || k == 8'h1A;
  endfunction

  function automatic bit too_short(int q);
`ifdef THROW_FOUL_EN
    return q < 4;
`else
    return q < 0;
`endif
  endfunction

  task automatic to_land();
    m_st = 4;
    m_land = 0;
    m_tv = 1;
    m_cmd = 0;
  endtask

  task automatic model_tick();
    int q;
    int k;
    q = quad(int'(BallX), int'(BallY));
    k = int'(keycode);
    case (m_st)
      0: begin
        if (k == 8'h2C) begin
          m_st = 1; m_q = 0; m_d = 0; m_oob = 0;
          m_cmd = 8'h2C;
        end else begin
          m_cmd = walk_key(k) ? k : 0;
        end
      end
      1: begin
        if (q == (m_pq + 1) % 4 && m_q < 255) m_q++;
        if (k != 8'h2C) begin
          m_st = 2;
          m_cmd = 0;
        end
      end
      2: begin
        m_fkey = fkey_of[q];
        m_bud = m_q * FPQ;
        if (too_short(m_q)) begin
          m_foul = 1; m_st = 0; m_cmd = 0;
        end else if (m_bud == 0) begin
          to_land();
        end else begin
          m_st = 3;
          m_cmd = m_fkey;
        end
      end
      3: begin
        m_d++;
        m_bud--;
        if (m_d > 2 && BallX == CX && BallY == CY) begin
          m_oob = 1;
          to_land();
        end else if (m_bud == 0) begin
          to_land();
        end
      end
      default: begin
        m_land++;
        if (m_land == LANDF) begin
          m_st = 0;
          m_cmd = 0;
        end
      end
    endcase
    m_pq = q;
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_cmd = 0; m_q = 0; m_d = 0; m_oob = 0;
      m_tv = 0; m_foul = 0; m_pq = 0; m_bud = 0;
      m_land = 0;
    end else begin
      m_tv = 0;
      m_foul = 0;
      if (frame_tick) model_tick();
    end
  end

  always @(negedge Clk) begin
    check("state", 32'(state), 32'(m_st));
    check("cmd", 32'(cmd_keycode), 32'(m_cmd));
    check("quarters", 32'(quarters), 32'(m_q));
    check("distance", 32'(distance), 32'(m_d));
    check("valid", 32'(throw_valid), 32'(m_tv));
    check("foul", 32'(foul), 32'(m_foul));
    check("oob", 32'(oob), 32'(m_oob));
  end

  task automatic set_pos(input int q);
    int dx;
    int dy;
    dx = int'($urandom_range(1, 100));
    dy = int'($urandom_range(1, 100));
    case (q)
      0:       begin BallX = 10'(CX + dx - 1); BallY = 10'(CY - dy); end
      1:       begin BallX = 10'(CX - dx); BallY = 10'(CY - dy); end
      2:       begin BallX = 10'(CX - dx); BallY = 10'(CY + dy - 1); end
      default: begin BallX = 10'(CX + dx); BallY = 10'(CY + dy); end
    endcase
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 7))
      0: return 8'h04;
      1: return 8'h07;
      2: return 8'h16;
      3: return 8'h1A;
      4: return 8'h2A;
      5: return 8'h2C;
      6: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  // random idle gap with keycode noise, then one tick Clk
  task automatic tick(input logic [7:0] k);
    int g;
    g = int'($urandom_range(0, 2));
    for (int i = 0; i < g; i++) begin
      keycode = 8'($urandom);
      @(negedge Clk);
    end
    keycode = k;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_to_idle(input int center_pct);
    int n;
    n = 0;
    while (m_st != 0 && n < 3000) begin
      if (int'($urandom_range(0, 99)) < center_pct) begin
        BallX = 10'(CX);
        BallY = 10'(CY);
      end else begin
        set_pos(int'($urandom_range(0, 3)));
      end
      tick(rand_key());
      n++;
    end
    check("reach_idle", 32'(m_st == 0), 32'd1);
  endtask

  initial begin
    int n16;
    int cq;
    int r;
    logic [7:0] k;
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cmd", 32'(cmd_keycode), 32'd0);
    check("rst_q", 32'(quarters), 32'd0);
    check("rst_dist", 32'(distance), 32'd0);
    check("rst_pulses", 32'({throw_valid, foul, oob}), 32'd0);
    Reset = 1'b0;

    set_pos(0);
    tick(8'h07);
    check("idle_pass", 32'(cmd_keycode), 32'h07);
    tick(8'h2A);
    check("idle_block", 32'(cmd_keycode), 32'h00);

    // legal 5-quarter throw released in Q1
    tick(8'h2C);
    check("wind_entry", 32'(state), 32'd1);
    check("wind_cmd", 32'(cmd_keycode), 32'h2C);
    for (int i = 1; i <= 5; i++) begin
      set_pos(i % 4);
      tick(8'h2C);
    end
    check("five_q", 32'(quarters), 32'd5);
    tick(8'h00);
    check("release", 32'(state), 32'd2);
    tick(8'h00);
    check("flight_key", 32'(cmd_keycode), 32'h16);
    n16 = 0;
    for (int i = 1; i < 30; i++) begin
      tick(rand_key());
      if (cmd_keycode == 8'h16 && state == 3'd3) n16++;
    end
    check("flight_hold", 32'(n16), 32'd29);
    tick(8'h00);
    check("land_state", 32'(state), 32'd4);
    check("land_valid", 32'(throw_valid), 32'd1);
    check("land_dist", 32'(distance), 32'd30);
    for (int i = 1; i < LANDF; i++) tick(8'h2C);
    check("land_hold", 32'(state), 32'd4);
    tick(8'h00);
    check("land_exit", 32'(state), 32'd0);
    check("land_keep_d", 32'(distance), 32'd30);

    // jitter Q1->Q0->Q1 counts only the CCW step
    set_pos(1);
    tick(8'h2C);
    set_pos(0);
    tick(8'h2C);
    check("jit_back", 32'(quarters), 32'd0);
    set_pos(1);
    tick(8'h2C);
    check("jit_fwd", 32'(quarters), 32'd1);
    set_pos(2);
    tick(8'h2C);
    check("jit_two", 32'(quarters), 32'd2);
    tick(8'h00);
    tick(8'h00);
`ifdef THROW_FOUL_EN
    check("foul_pulse", 32'(foul), 32'd1);
    check("foul_state", 32'(state), 32'd0);
    check("foul_cmd", 32'(cmd_keycode), 32'h00);
    check("foul_nodist", 32'(distance), 32'd0);
`else
    check("short_fly", 32'(state), 32'd3);
    run_to_idle(0);
    set_pos(2);
    tick(8'h2C);
    tick(8'h00);
    tick(8'h00);
    check("zero_land", 32'(state), 32'd4);
    check("zero_valid", 32'(throw_valid), 32'd1);
    check("zero_dist", 32'(distance), 32'd0);
    run_to_idle(0);
`endif

    // 20-quarter throw forced out of bounds on flight tick 10
    set_pos(0);
    tick(8'h2C);
    for (int i = 1; i <= 20; i++) begin
      set_pos(i % 4);
      tick(8'h2C);
    end
    check("twenty_q", 32'(quarters), 32'd20);
    tick(8'h00);
    tick(8'h00);
    check("oob_key", 32'(cmd_keycode), 32'h04);
    for (int i = 1; i < 10; i++) begin
      set_pos(int'($urandom_range(0, 3)));
      tick(rand_key());
    end
    BallX = 10'(CX);
    BallY = 10'(CY);
    tick(8'h00);
    check("oob_flag", 32'(oob), 32'd1);
    check("oob_dist", 32'(distance), 32'd10);
    check("oob_valid", 32'(throw_valid), 32'd1);
    check("oob_state", 32'(state), 32'd4);
    run_to_idle(0);
    check("oob_keep", 32'(oob), 32'd1);

    // reset asserted mid-flight
    set_pos(0);
    tick(8'h2C);
    for (int i = 1; i <= 8; i++) begin
      set_pos(i % 4);
      tick(8'h2C);
    end
    tick(8'h00);
    tick(8'h00);
    repeat (3) tick(8'h00);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("mid_state", 32'(state), 32'd0);
    check("mid_cmd", 32'(cmd_keycode), 32'd0);
    check("mid_cnt", 32'({quarters, distance}), 32'd0);
    check("mid_pulse", 32'({throw_valid, foul, oob}), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // random throws
    for (int t = 0; t < 25; t++) begin
      r = int'($urandom_range(0, 4));
      for (int i = 0; i < r; i++) begin
        k = rand_key();
        if (k == 8'h2C) k = 8'h00;
        set_pos(int'($urandom_range(0, 3)));
        tick(k);
      end
      cq = int'($urandom_range(0, 3));
      set_pos(cq);
      tick(8'h2C);
      r = int'($urandom_range(0, 30));
      for (int i = 0; i < r; i++) begin
        n16 = int'($urandom_range(0, 99));
        if (n16 < 65) cq = (cq + 1) % 4;
        else if (n16 >= 80) cq = int'($urandom_range(0, 3));
        set_pos(cq);
        tick(8'h2C);
      end
      k = rand_key();
      if (k == 8'h2C) k = 8'h2A;
      tick(k);
      run_to_idle(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
